ahbl_apb_bridge: RTL
====================

AHBL_APB_BRIDGE -- requirements
Module: ahbl_apb_bridge

Interface
REQ-001 Parameter W_ADDR, default 32: AHB and APB address width.
REQ-002 Parameter W_DATA, default 32: data width; only 32 is supported.
REQ-003 Parameter TIMEOUT, default 255: maximum APB wait cycles before abort; 0 disables the timeout.
REQ-004 clk  in  1  single clock for both the AHB and APB sides.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 hready  in  1  bus HREADY; an address phase is sampled only when it is 1.
REQ-007 hready_resp  out  1  slave HREADYOUT.
REQ-008 hresp  out  1  slave HRESP; 1 = ERROR.
REQ-009 haddr  in  W_ADDR  AHB address.
REQ-010 hwrite  in  1  AHB direction; 1 = write.
REQ-011 htrans  in  2  AHB transfer type; bit 1 set = NONSEQ or SEQ.
REQ-012 hsize  in  3  AHB transfer size.
REQ-013 hwdata  in  W_DATA  AHB write data, valid in the data phase.
REQ-014 hrdata  out  W_DATA  AHB read data.
REQ-015 paddr  out  W_ADDR  APB address.
REQ-016 psel  out  1  APB select.
REQ-017 penable  out  1  APB enable.
REQ-018 pwrite  out  1  APB direction.
REQ-019 pwdata  out  W_DATA  APB write data.
REQ-020 pstrb  out  4  APB write byte strobes.
REQ-021 prdata  in  W_DATA  APB read data.
REQ-022 pready  in  1  APB ready.
REQ-023 pslverr  in  1  APB slave error.

Function
REQ-024 Accept a transfer when hready=1, htrans[1]=1 and state is IDLE or ERR2; register haddr, hwrite and hsize at acceptance.
REQ-025 States and transitions:
- IDLE: accept -> WDATA if write, SETUP if read.
- WDATA: capture hwdata into pwdata -> SETUP.
- SETUP: psel=1, penable=0 -> ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=1, pslverr=0 -> IDLE.
  - pready=1, pslverr=1 -> ERR1.
  - timeout -> ERR1.
- ERR1 -> ERR2.
- ERR2 -> SETUP, WDATA or IDLE, per REQ-024.
REQ-026 hready_resp SHALL be 0 in WDATA, SETUP, ACCESS and ERR1, and 1 in IDLE and ERR2.
REQ-027 hresp SHALL be 1 in ERR1 and ERR2 only, giving the two-cycle AHB error response.
REQ-028 paddr, pwrite, pstrb and pwdata SHALL be stable from SETUP through the last ACCESS cycle.
REQ-029 pstrb for writes:
- hsize=0: 4'b0001 shifted left by haddr[1:0].
- hsize=1: 4'b0011 if haddr[1]=0, else 4'b1100.
- hsize=2: 4'b1111.
- Reads: 4'b0000.
REQ-030 Transfer with hsize>2: no APB access; IDLE -> ERR1 directly (WDATA skipped).
REQ-031 Read completion: hrdata is registered from prdata on the ACCESS cycle with pready=1 and is held until the next read completes.
REQ-032 Latency with zero-wait APB, counted from the acceptance cycle to the cycle with hready_resp=1 again: read 3 cycles, write 4 cycles.
REQ-033 Timeout counter: cleared on entry to ACCESS; increments each ACCESS cycle with pready=0.
- TIMEOUT>0 and count reaches TIMEOUT: drop psel and penable -> ERR1.
- The counter saturates and never wraps.
REQ-034 htrans=IDLE or BUSY, or hready=0 while in IDLE: no state change, outputs unchanged.
REQ-035 Back-to-back transfers: the next address phase is accepted in the same cycle hready_resp returns to 1, with no bubble.
REQ-036 pready is ignored outside ACCESS; pslverr is ignored unless pready=1.

Reset
REQ-037 While rst=1, asynchronously force:
- state IDLE;
- psel=0, penable=0, pwrite=0;
- paddr=0, pwdata=0, pstrb=0, hrdata=0;
- hready_resp=1, hresp=0;
- timeout counter 0.
REQ-038 rst asserted mid-transfer aborts the transfer with no completion or error response; the first transfer after rst is released starts from IDLE.

Verification
REQ-039 Read of 0x4000_0010, pready=1 immediately, prdata=0xDEAD_BEEF -> SETUP one cycle, ACCESS one cycle, hrdata=0xDEAD_BEEF, hready_resp=1 three cycles after acceptance.
REQ-040 Byte write to 0x4000_0003, hwdata=0x1122_3344, pready low for 3 cycles -> pstrb=4'b1000, pwdata=0x1122_3344 stable for all 4 ACCESS cycles.
REQ-041 Write with pslverr=1 on the ACCESS cycle -> hresp=1 for 2 cycles; hready_resp=0 in the first error cycle and 1 in the second.
REQ-042 TIMEOUT=4, pready held 0 -> after 4 ACCESS cycles psel drops and the ERR1/ERR2 response follows; the next transfer completes normally.
REQ-043 Back-to-back read then halfword write to 0x..02 -> the write is accepted on the read's final hready_resp=1 cycle with pstrb=4'b1100; hsize=3 -> error response with psel never asserted.
REQ-044 rst pulsed during ACCESS -> psel and penable fall in the same cycle and all outputs take their REQ-037 values.

Source files
------------

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one outstanding transfer, single clock,
// two-cycle AHB error response on APB error, APB timeout or unsupported hsize.
module ahbl_apb_bridge #(
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hready,
   output logic              hready_resp,
   output logic              hresp,
   input  logic [W_ADDR-1:0] haddr,
   input  logic              hwrite,
   input  logic [1:0]        htrans,
   input  logic [2:0]        hsize,
   input  logic [W_DATA-1:0] hwdata,
   output logic [W_DATA-1:0] hrdata,
   output logic [W_ADDR-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [W_DATA-1:0] pwdata,
   output logic [3:0]        pstrb,
   input  logic [W_DATA-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WDATA  = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_ERR1   = 3'd4;
   localparam logic [2:0] S_ERR2   = 3'd5;

   localparam int W_CNT = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [W_CNT-1:0] CNT_MAX  = '1;
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [2:0]        state_q, state_d;
   logic [W_ADDR-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [W_DATA-1:0] pwdata_q, pwdata_d;
   logic [W_DATA-1:0] hrdata_q, hrdata_d;
   logic [W_CNT-1:0]  cnt_q, cnt_d;
   logic              accept;
   logic              unused_htrans0;

   assign unused_htrans0 = htrans[0];
   assign accept = hready & htrans[1];

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      hsize_d  = hsize_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE, S_ERR2: begin
            if (accept) begin
               paddr_d  = haddr;
               pwrite_d = hwrite;
               hsize_d  = hsize;
               if (hsize > 3'd2)  state_d = S_ERR1;
               else if (hwrite)   state_d = S_WDATA;
               else               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WDATA: begin
            pwdata_d = hwdata;
            state_d  = S_SETUP;
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (pready) begin
               if (!pwrite_q) hrdata_d = prdata;
               state_d = pslverr ? S_ERR1 : S_IDLE;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + W_CNT'(1);
               // abort at the end of the TIMEOUT-th waited ACCESS cycle
               if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) state_d = S_ERR1;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         hsize_q  <= '0;
         pwdata_q <= '0;
         hrdata_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         hsize_q  <= hsize_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
         cnt_q    <= cnt_d;
      end
   end

   // strobes derive from registered fields so they hold for the whole APB access
   always_comb begin
      pstrb = 4'b0000;
      if (pwrite_q) begin
         case (hsize_q)
            3'd0:    pstrb = 4'b0001 << paddr_q[1:0];
            3'd1:    pstrb = paddr_q[1] ? 4'b1100 : 4'b0011;
            3'd2:    pstrb = 4'b1111;
            default: pstrb = 4'b0000;
         endcase
      end
   end

   assign psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign penable     = (state_q == S_ACCESS);
   assign hready_resp = (state_q == S_IDLE) || (state_q == S_ERR2);
   assign hresp       = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign hrdata      = hrdata_q;

endmodule
